// File: rtl/raid5_pkg.sv
// Shared types and constants for the stripe read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the card id type (0 = no card), the sd_error field layout, the word
// and block geometry and the assembler state encoding.
package raid5_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 128;
  localparam int ADDR_W      = $clog2(BLOCK_WORDS);

  // sd_error carries one 2-bit error code per card, sd1 in the low bits.
  localparam int SD_ERR_W    = 2;
  localparam int SD1_ERR_LSB = 0;
  localparam int SD2_ERR_LSB = 2;
  localparam int SD3_ERR_LSB = 4;
  localparam int SD_ERR_BITS = 3 * SD_ERR_W;

  typedef logic [1:0] sd_id_t;
  localparam sd_id_t SD_NONE = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE,
    FAIL
  } asm_state_t;

  // One bit per card (bit 0 = sd1): set when that card reports any error.
  function automatic logic [2:0] failed_mask(input logic [SD_ERR_BITS-1:0] err);
    failed_mask = {|err[SD3_ERR_LSB +: SD_ERR_W],
                   |err[SD2_ERR_LSB +: SD_ERR_W],
                   |err[SD1_ERR_LSB +: SD_ERR_W]};
  endfunction

endpackage

// File: rtl/stripe_read_assembler_if.sv
// Bundle of all card-side, SRAM-side and control signals of the assembler.
// Latency: n/a (wiring only).
// Backpressure: sd_word_ready from the assembler gates sd_word_valid words.
//
// Modports: slave = the assembler itself, master = whoever feeds cards and
// sinks SRAM writes/status (control unit or bench).
interface stripe_read_assembler_if;
  import raid5_pkg::*;

  logic                   start;
  sd_id_t                 sram1sd;
  sd_id_t                 sram2sd;
  logic [SD_ERR_BITS-1:0] sd_error;
  logic                   sd_word_valid;
  logic                   sd_word_ready;
  logic [WORD_W-1:0]      sd1_data;
  logic [WORD_W-1:0]      sd2_data;
  logic [WORD_W-1:0]      sd3_data;
  logic                   sram1_write_enable;
  logic                   sram2_write_enable;
  logic [ADDR_W-1:0]      sram_address;
  logic [WORD_W-1:0]      sram1_write_data;
  logic [WORD_W-1:0]      sram2_write_data;
  logic                   busy;
  logic                   done;
  logic                   fatal;
  logic                   recovered;
  logic                   parity_fault;

  modport slave (
    input  start, sram1sd, sram2sd, sd_error, sd_word_valid,
           sd1_data, sd2_data, sd3_data,
    output sd_word_ready, sram1_write_enable, sram2_write_enable,
           sram_address, sram1_write_data, sram2_write_data,
           busy, done, fatal, recovered, parity_fault
  );

  modport master (
    output start, sram1sd, sram2sd, sd_error, sd_word_valid,
           sd1_data, sd2_data, sd3_data,
    input  sd_word_ready, sram1_write_enable, sram2_write_enable,
           sram_address, sram1_write_data, sram2_write_data,
           busy, done, fatal, recovered, parity_fault
  );

endinterface

// File: rtl/sd_word_reconstruct.sv
// Maps the three card words onto SRAM1/SRAM2, rebuilding a failed data card.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the outputs are used.
//
// Ports: sd1/2/3_word card words; sram1_id/sram2_id card feeding each SRAM;
// failed one bit per card; sram1/2_word mapped words; parity_ok high when the
// three words XOR to zero (tied high unless PARITY_CHECK_EN is defined).
module sd_word_reconstruct
  import raid5_pkg::*;
(
  input  logic [WORD_W-1:0] sd1_word,
  input  logic [WORD_W-1:0] sd2_word,
  input  logic [WORD_W-1:0] sd3_word,
  input  sd_id_t            sram1_id,
  input  sd_id_t            sram2_id,
  input  logic [2:0]        failed,
  output logic [WORD_W-1:0] sram1_word,
  output logic [WORD_W-1:0] sram2_word,
  output logic              parity_ok
);

  logic [WORD_W-1:0] all_xor;

  function automatic logic [WORD_W-1:0] card_word(input sd_id_t id,
                                                  input logic [WORD_W-1:0] w1,
                                                  input logic [WORD_W-1:0] w2,
                                                  input logic [WORD_W-1:0] w3);
    case (id)
      2'd1:    card_word = w1;
      2'd2:    card_word = w2;
      2'd3:    card_word = w3;
      default: card_word = '0;
    endcase
  endfunction

  function automatic logic card_failed(input sd_id_t id, input logic [2:0] mask);
    case (id)
      2'd1:    card_failed = mask[0];
      2'd2:    card_failed = mask[1];
      2'd3:    card_failed = mask[2];
      default: card_failed = 1'b0;
    endcase
  endfunction

  always_comb begin
    all_xor    = sd1_word ^ sd2_word ^ sd3_word;
    sram1_word = card_word(sram1_id, sd1_word, sd2_word, sd3_word);
    sram2_word = card_word(sram2_id, sd1_word, sd2_word, sd3_word);
    // XOR-ing the failed card's own word back out of the 3-way XOR leaves
    // the XOR of the two surviving cards, i.e. the rebuilt data word.
    if (card_failed(sram1_id, failed)) sram1_word = all_xor ^ sram1_word;
    if (card_failed(sram2_id, failed)) sram2_word = all_xor ^ sram2_word;
  end

`ifdef PARITY_CHECK_EN
  assign parity_ok = (all_xor == '0);
`else
  assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/stripe_read_assembler.sv
// Assembles one 128-word block from three SD cards into SRAM1/SRAM2.
// Latency: SRAM write appears the cycle after each accepted word; done two cycles after the last.
// Backpressure: sd_word_ready high only in STREAM; valid gaps stall without writes.
//
// Ports: clk, n_rst (async, active low); bus = stripe_read_assembler_if.slave
// carrying start/mapping/sd_error, the card word handshake, SRAM write port
// and busy/done/fatal/recovered/parity_fault status.
// Optional: PARITY_CHECK_EN enables the sticky parity_fault check.
module stripe_read_assembler
  import raid5_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  stripe_read_assembler_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLOCK_WORDS - 1);

  asm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  sd_id_t            map1_q, map1_d;
  sd_id_t            map2_q, map2_d;
  logic [2:0]        failed_q, failed_d;
  logic              we_q, we_d;
  logic              rec_q, rec_d;
  logic [WORD_W-1:0] wd1_q, wd1_d;
  logic [WORD_W-1:0] wd2_q, wd2_d;
`ifdef PARITY_CHECK_EN
  logic              pf_q, pf_d;
`endif

  logic [2:0]        start_failed;
  logic              bad_map;
  logic              multi_fail;
  logic [WORD_W-1:0] rec1_word, rec2_word;
  logic              parity_ok;

  sd_word_reconstruct u_recon (
    .sd1_word   (bus.sd1_data),
    .sd2_word   (bus.sd2_data),
    .sd3_word   (bus.sd3_data),
    .sram1_id   (map1_q),
    .sram2_id   (map2_q),
    .failed     (failed_q),
    .sram1_word (rec1_word),
    .sram2_word (rec2_word),
    .parity_ok  (parity_ok)
  );

  assign start_failed = failed_mask(bus.sd_error);
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_fail   = (start_failed & (start_failed - 3'd1)) != 3'd0;
  assign bad_map      = (bus.sram1sd == bus.sram2sd) ||
                        (bus.sram1sd == SD_NONE) || (bus.sram2sd == SD_NONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    map1_d   = map1_q;
    map2_d   = map2_q;
    failed_d = failed_q;
    we_d     = 1'b0;
    rec_d    = rec_q;
    wd1_d    = wd1_q;
    wd2_d    = wd2_q;
`ifdef PARITY_CHECK_EN
    pf_d     = pf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          map1_d   = bus.sram1sd;
          map2_d   = bus.sram2sd;
          failed_d = start_failed;
          rec_d    = 1'b0;
          cnt_d    = '0;
          addr_d   = '0;
`ifdef PARITY_CHECK_EN
          pf_d     = 1'b0;
`endif
          state_d  = (bad_map || multi_fail) ? FAIL : STREAM;
        end
      end
      STREAM: begin
        if (bus.sd_word_valid) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          wd1_d  = rec1_word;
          wd2_d  = rec2_word;
          if (failed_q != 3'd0) rec_d = 1'b1;
`ifdef PARITY_CHECK_EN
          // Parity is only meaningful when all three cards are trusted.
          if ((failed_q == 3'd0) && !parity_ok) pf_d = 1'b1;
`endif
          if (cnt_q == LAST_IDX) state_d = DRAIN;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      map1_q   <= SD_NONE;
      map2_q   <= SD_NONE;
      failed_q <= '0;
      we_q     <= 1'b0;
      rec_q    <= 1'b0;
      wd1_q    <= '0;
      wd2_q    <= '0;
`ifdef PARITY_CHECK_EN
      pf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      map1_q   <= map1_d;
      map2_q   <= map2_d;
      failed_q <= failed_d;
      we_q     <= we_d;
      rec_q    <= rec_d;
      wd1_q    <= wd1_d;
      wd2_q    <= wd2_d;
`ifdef PARITY_CHECK_EN
      pf_q     <= pf_d;
`endif
    end
  end

  assign bus.sd_word_ready      = (state_q == STREAM);
  assign bus.busy               = (state_q != IDLE);
  assign bus.done               = (state_q == DONE);
  assign bus.fatal              = (state_q == FAIL);
  assign bus.recovered          = rec_q;
  assign bus.sram1_write_enable = we_q;
  assign bus.sram2_write_enable = we_q;
  assign bus.sram_address       = addr_q;
  assign bus.sram1_write_data   = wd1_q;
  assign bus.sram2_write_data   = wd2_q;

`ifdef PARITY_CHECK_EN
  assign bus.parity_fault = pf_q;
`else
  logic unused_parity_ok;
  assign unused_parity_ok = parity_ok;
  assign bus.parity_fault = 1'b0;
`endif

endmodule

// File: tb/tb_stripe_read_assembler.sv
// Randomized bench for stripe_read_assembler against a block-level model.
// Latency: n/a.
// Backpressure: bench inserts random valid gaps.
module tb_stripe_read_assembler;
  import raid5_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  stripe_read_assembler_if bus ();

  stripe_read_assembler dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Card words per block, indexed [card 1..3][word].
  logic [WORD_W-1:0] wd [1:3][0:BLOCK_WORDS-1];

  // Observed SRAM writes and status pulses, appended by the monitor only.
  logic [ADDR_W-1:0] mon_addr [$];
  logic [WORD_W-1:0] mon_d1   [$];
  logic [WORD_W-1:0] mon_d2   [$];
  int   done_cnt  = 0;
  int   fatal_cnt = 0;
  logic acc_prev  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: writes must come in pairs and exactly one
  // cycle after each word the bench handed over.
  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        acc_prev = 1'b0;
      end else begin
        chk("we_pair", {31'd0, bus.sram1_write_enable}, {31'd0, bus.sram2_write_enable});
        chk("we_after_accept", {31'd0, bus.sram1_write_enable}, {31'd0, acc_prev});
        if (bus.sram1_write_enable) begin
          mon_addr.push_back(bus.sram_address);
          mon_d1.push_back(bus.sram1_write_data);
          mon_d2.push_back(bus.sram2_write_data);
        end
        if (bus.done)  done_cnt++;
        if (bus.fatal) fatal_cnt++;
        acc_prev = bus.sd_word_valid && bus.sd_word_ready;
      end
    end
  end

  task automatic fill_const();
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      wd[1][i] = 32'h66666666;
      wd[2][i] = 32'hFFFFFFFF;
      wd[3][i] = 32'h99999999;
    end
  endtask

  // Consistent stripe: parity card = XOR of the two data cards; a failed
  // card then carries garbage.
  task automatic fill_random(input int m1, input int m2, input int fcard);
    int p;
    logic [WORD_W-1:0] a, b;
    p = 6 - m1 - m2;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      a = $urandom;
      b = $urandom;
      wd[m1][i] = a;
      wd[m2][i] = b;
      wd[p][i]  = a ^ b;
      if (fcard != 0) wd[fcard][i] = $urandom;
    end
  endtask

  // Expected SRAM word for card m: that card's word, or the XOR of the other
  // two cards when m is the failed card.
  function automatic logic [WORD_W-1:0] exp_word(input int m, input int f, input int i);
    logic [WORD_W-1:0] r;
    if (m != f) return wd[m][i];
    r = '0;
    for (int c = 1; c <= 3; c++) if (c != m) r = r ^ wd[c][i];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, {24'd0, bus.busy, bus.sd_word_ready, bus.sram1_write_enable,
        bus.sram2_write_enable, bus.done, bus.fatal, bus.recovered, bus.parity_fault}, 32'd0);
    chk({tag, "_addr"}, {25'd0, bus.sram_address}, 32'd0);
    chk({tag, "_d1"}, bus.sram1_write_data, 32'd0);
    chk({tag, "_d2"}, bus.sram2_write_data, 32'd0);
  endtask

  // Runs one block from IDLE; entered and left #1 after a rising edge.
  task automatic run_block(input string tag, input int m1, input int m2,
                           input logic [5:0] err, input int gap_pct, input int abort_at);
    int f, nfail, base, dbase, fbase, i, cyc, nw;
    bit exp_fatal, exp_pf, acc;

    f = 0; nfail = 0;
    for (int c = 1; c <= 3; c++) if (err[2*(c-1) +: 2] != 2'b00) begin f = c; nfail++; end
    exp_fatal = (m1 == m2) || (m1 == 0) || (m2 == 0) || (nfail > 1);
    exp_pf = 1'b0;
`ifdef PARITY_CHECK_EN
    if (f == 0)
      for (int j = 0; j < BLOCK_WORDS; j++)
        if ((wd[1][j] ^ wd[2][j] ^ wd[3][j]) != '0) exp_pf = 1'b1;
`endif
    base = mon_addr.size(); dbase = done_cnt; fbase = fatal_cnt;

    bus.start = 1'b1;
    bus.sram1sd = sd_id_t'(m1);
    bus.sram2sd = sd_id_t'(m2);
    bus.sd_error = err;
    bus.sd_word_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // Mapping and errors are latched; scrambling them now must not matter.
    bus.sd_error = 6'($urandom);
    bus.sram1sd = sd_id_t'($urandom);
    bus.sram2sd = sd_id_t'($urandom);
    chk({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_rec_clr"}, {31'd0, bus.recovered}, 32'd0);
    chk({tag, "_pf_clr"}, {31'd0, bus.parity_fault}, 32'd0);

    if (exp_fatal) begin
      chk({tag, "_fatal"}, {31'd0, bus.fatal}, 32'd1);
      chk({tag, "_rdy_fail"}, {31'd0, bus.sd_word_ready}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_fatal_end"}, {30'd0, bus.fatal, bus.busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_no_writes"}, mon_addr.size() - base, 32'd0);
      chk({tag, "_fatal_cnt"}, fatal_cnt - fbase, 32'd1);
      return;
    end

    chk({tag, "_rdy_start"}, {31'd0, bus.sd_word_ready}, 32'd1);
    chk({tag, "_nofatal"}, {31'd0, bus.fatal}, 32'd0);

    i = 0; cyc = 0;
    while (i < BLOCK_WORDS && cyc < 4000) begin
      if (i == abort_at) begin
        n_rst = 1'b0;
        #1;
        check_all_zero({tag, "_rst"});
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        bus.sd_word_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rst_idle"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_rst_nodone"}, done_cnt - dbase, 32'd0);
        return;
      end
      bus.sd_word_valid = ($urandom_range(99) >= gap_pct);
      bus.sd1_data = bus.sd_word_valid ? wd[1][i] : $urandom;
      bus.sd2_data = bus.sd_word_valid ? wd[2][i] : $urandom;
      bus.sd3_data = bus.sd_word_valid ? wd[3][i] : $urandom;
      acc = bus.sd_word_valid && bus.sd_word_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
    end
    bus.sd_word_valid = 1'b0;
    chk({tag, "_words_taken"}, i, BLOCK_WORDS);

    // Cycle after the last accept: DRAIN, then one DONE cycle, then IDLE.
    chk({tag, "_drain"}, {29'd0, bus.busy, bus.sd_word_ready, bus.done}, 32'b100);
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);

    nw = mon_addr.size() - base;
    chk({tag, "_nwrites"}, nw, BLOCK_WORDS);
    if (nw > BLOCK_WORDS) nw = BLOCK_WORDS;
    for (int j = 0; j < nw; j++) begin
      if (mon_addr[base+j] != ADDR_W'(j))
        chk({tag, "_addr"}, {25'd0, mon_addr[base+j]}, j);
      if (mon_d1[base+j] != exp_word(m1, f, j))
        chk({tag, "_sram1"}, mon_d1[base+j], exp_word(m1, f, j));
      if (mon_d2[base+j] != exp_word(m2, f, j))
        chk({tag, "_sram2"}, mon_d2[base+j], exp_word(m2, f, j));
    end
    chk({tag, "_block_data"}, 32'(nw), BLOCK_WORDS);
    chk({tag, "_done_cnt"}, done_cnt - dbase, 32'd1);
    chk({tag, "_fatal_cnt"}, fatal_cnt - fbase, 32'd0);
    chk({tag, "_recovered"}, {31'd0, bus.recovered}, {31'd0, f != 0});
    chk({tag, "_parity_fault"}, {31'd0, bus.parity_fault}, {31'd0, exp_pf});
  endtask

  initial begin
    int m1, m2, p, f;
    logic [5:0] err;

    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.sram1sd = SD_NONE;
    bus.sram2sd = SD_NONE;
    bus.sd_error = '0;
    bus.sd_word_valid = 1'b0;
    bus.sd1_data = '0;
    bus.sd2_data = '0;
    bus.sd3_data = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    fill_const();
    run_block("good", 2, 3, 6'b000000, 0, -1);
    run_block("rec_sd2", 2, 3, 6'b000100, 0, -1);
    run_block("par_sd1", 2, 3, 6'b000001, 0, -1);
    run_block("two_fail", 2, 3, 6'b110100, 0, -1);
    run_block("same_map", 2, 2, 6'b000000, 0, -1);
    run_block("zero_map", 0, 3, 6'b000000, 0, -1);

    fill_random(1, 3, 0);
    run_block("abort", 1, 3, 6'b000000, 30, 60);
    run_block("restart", 1, 3, 6'b000000, 30, -1);

    fill_const();
    wd[3][5] = 32'h99999998;
    run_block("pfault", 2, 3, 6'b000000, 0, -1);
    repeat (4) @(posedge clk);
    #1;
`ifdef PARITY_CHECK_EN
    chk("pfault_sticky", {31'd0, bus.parity_fault}, 32'd1);
`else
    chk("pfault_sticky", {31'd0, bus.parity_fault}, 32'd0);
`endif

    for (int r = 0; r < 6; r++) begin
      m1 = $urandom_range(1, 3);
      m2 = (m1 % 3) + 1 + int'($urandom_range(0, 1));
      if (m2 > 3) m2 = m2 - 3;
      p = 6 - m1 - m2;
      f = $urandom_range(0, 3);
      err = '0;
      if (f != 0) err[2*(f-1) +: 2] = 2'($urandom_range(1, 3));
      if (p < 1 || p > 3) p = 1;
      fill_random(m1, m2, f);
      run_block("rand", m1, m2, err, 25, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stripe_read_assembler.md
# stripe_read_assembler

Read-path counterpart of the stripe write path (parity generation plus per-card data-in select). Accepts one word per card from the three SD cards, maps the two data cards to SRAM1/SRAM2, and reconstructs a single failed data card from parity. Writes one 128-word block into the two on-chip SRAM buffers, then reports done/recovered/fatal status to the control unit.

## Interface
- WORD_W, 32, SD/SRAM word width
- BLOCK_WORDS, 128, words per block per card
- ADDR_W, 7, SRAM word-address width (log2 BLOCK_WORDS)
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin one block; sampled only in IDLE
- sram1sd, sram2sd  in  2 each  card (1..3) holding SRAM1/SRAM2 data; the remaining card holds parity
- sd_error  in  6  per-card error: [1:0] sd1, [3:2] sd2, [5:4] sd3; nonzero means card failed
- sd_word_valid  in  1  sd1/2/3_data hold a word
- sd_word_ready  out  1  block accepts a word this cycle
- sd1_data, sd2_data, sd3_data  in  WORD_W  card words
- sram1_write_enable, sram2_write_enable  out  1  write strobes
- sram_address  out  ADDR_W  word index within the block
- sram1_write_data, sram2_write_data  out  WORD_W
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, block written
- fatal  out  1  one-cycle pulse, block cannot be assembled
- recovered  out  1  sticky: block used reconstruction; cleared on start
- parity_fault  out  1  sticky: parity mismatch seen; cleared on start

## Operation
- States: IDLE, STREAM, DRAIN, DONE, FAIL.
- IDLE: start=1 latches sram1sd, sram2sd and failed-card mask (sd_error pairs != 0); clears recovered, parity_fault and the word counter.
- Start checks, in order: sram1sd==sram2sd, either is 0, or more than one failed card -> FAIL; otherwise -> STREAM. FAIL pulses fatal for one cycle, then IDLE.
- STREAM: sd_word_ready=1. When valid&&ready, capture the mapped words.
  - Failed card is a data card: its word = XOR of the other two cards; set recovered.
  - Failed card is the parity card: data used directly; set recovered.
- Counter increments per accepted word. Acceptance at index BLOCK_WORDS-1 -> DRAIN.
- DRAIN: sd_word_ready=0; final write issued -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start is ignored in all states other than IDLE. sd_error changes after start are ignored; the latched mask is used.
- Reset at any time: state IDLE; all outputs 0; counter, sticky flags and latched mapping cleared. A partial block is abandoned with no done pulse.

## Timing
- Reset values: every output 0.
- start sampled high at edge E0: busy=1 and sd_word_ready=1 from E0 onward.
- Word accepted at edge Ek: write enables, address=k and data are valid for the cycle after Ek.
- Both write enables assert together, one cycle per accepted word, and never without a preceding accept.
- Minimum block length (valid held high): 1 start cycle + 128 accept cycles + 1 DRAIN + 1 DONE.
- valid gaps stall the transfer with no write. Address never wraps within a block; it is reset to 0 on start.

## Configuration
- PARITY_CHECK_EN defined: on each accepted word with no failed card, sd1^sd2^sd3 != 0 sets parity_fault. Data is still written.
- PARITY_CHECK_EN undefined: parity_fault is tied 0 and no check logic is present.

## Structure
- Shared package raid5_pkg holds:
  - sd_id_t (2-bit card id; 0 = none)
  - sd_error field layout constants
  - WORD_W and BLOCK_WORDS defaults
  - state enum asm_state_t
- One sub-module, sd_word_reconstruct: combinational. Inputs: three words, mapping, failed mask. Outputs: sram1/sram2 words and parity_ok.

## Test plan
- All cards good; sram1sd=2, sram2sd=3; sd1=0x66666666, sd2=0xFFFFFFFF, sd3=0x99999999 for 128 words -> SRAM1=0xFFFFFFFF, SRAM2=0x99999999 at addresses 0..127; done pulses once; recovered=0, parity_fault=0.
- Same stream, sd_error[3:2]=2'b01 -> SRAM1=0x66666666^0x99999999=0xFFFFFFFF; recovered=1.
- Parity card sd1 failed -> data written unchanged; recovered=1; no fatal.
- Two cards failed, or sram1sd=sram2sd=2, at start -> fatal pulse one cycle after start, no write strobes, busy=0 next cycle.
- Random valid gaps plus n_rst pulsed at word 60 -> outputs zero immediately; a restarted block completes with addresses 0..127 and exactly 128 writes.
- With PARITY_CHECK_EN: sd3=0x99999998 on word 5 -> parity_fault=1 and sticky until next start. Without the macro -> parity_fault stays 0.
